// File: rtl/mips_bus_memory_responder.sv
// Memory-mapped responder for the mips_cpu_bus initiator: instruction and data word regions,
// byte-lane writes, programmable wait states and error flagging.
module mips_bus_memory_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter logic [31:0] INSTR_BASE  = 32'hBFC00000,
    parameter logic [31:0] DATA_BASE   = 32'h00000000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = "",
    localparam int unsigned IdxW       = $clog2(DEPTH_WORDS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     address,
    input  logic            read,
    input  logic            write,
    input  logic [3:0]      byteenable,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic            waitrequest,
    output logic            err,
    input  logic            dbg_region,
    input  logic [IdxW-1:0] dbg_index,
    output logic [31:0]     dbg_word
);

    typedef enum logic [1:0] {StIdle, StBusy, StAck} state_e;

    localparam logic [31:0] RegionBytes = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  CntInit     = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0] imem [DEPTH_WORDS];
    logic [31:0] dmem [DEPTH_WORDS];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, wdata_q, readdata_q;
    logic        rd_q, wr_q;
    logic [3:0]  be_q;

    logic [31:0] cur_addr, cur_wdata, off_i, off_d, lane_mask, mem_word;
    logic [3:0]  cur_be;
    logic        cur_rd, cur_wr, hit_i, hit_d, bad, enter_ack;
    logic [IdxW-1:0] idx;

    // Power-up image only; contents are never cleared by reset.
    initial begin
        for (int i = 0; i < int'(DEPTH_WORDS); i++) begin
            imem[i] = 32'h0;
            dmem[i] = 32'h0;
        end
    end

    // In IDLE the live request is decoded so a zero-wait transfer can commit on its capture edge.
    always_comb begin
        cur_addr  = (state_q == StIdle) ? address    : addr_q;
        cur_rd    = (state_q == StIdle) ? read       : rd_q;
        cur_wr    = (state_q == StIdle) ? write      : wr_q;
        cur_be    = (state_q == StIdle) ? byteenable : be_q;
        cur_wdata = (state_q == StIdle) ? writedata  : wdata_q;
        off_i     = cur_addr - INSTR_BASE;
        off_d     = cur_addr - DATA_BASE;
        hit_i     = off_i < RegionBytes;
        hit_d     = off_d < RegionBytes;
        idx       = hit_i ? off_i[IdxW+1:2] : off_d[IdxW+1:2];
        bad       = (cur_addr[1:0] != 2'b00) || !(hit_i || hit_d) || (cur_rd && cur_wr);
        mem_word  = hit_i ? imem[idx] : dmem[idx];
        lane_mask = {{8{cur_be[3]}}, {8{cur_be[2]}}, {8{cur_be[1]}}, {8{cur_be[0]}}};
        enter_ack = reset && (state_d == StAck) && (state_q != StAck);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            readdata_q <= 32'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            be_q       <= 4'h0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && (read || write)) begin
                addr_q  <= address;
                rd_q    <= read;
                wr_q    <= write;
                be_q    <= byteenable;
                wdata_q <= writedata;
            end
            if (enter_ack && cur_rd) begin
                readdata_q <= bad ? 32'h0 : (mem_word & lane_mask);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enter_ack && cur_wr && !bad) begin
            for (int k = 0; k < 4; k++) begin
                if (cur_be[k]) begin
                    if (hit_i) imem[idx][8*k +: 8] <= cur_wdata[8*k +: 8];
                    else       dmem[idx][8*k +: 8] <= cur_wdata[8*k +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (read || write) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = StAck;
                    end else begin
                        state_d = StBusy;
                        cnt_d   = CntInit;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) state_d = StAck;
                else               cnt_d   = cnt_q - 4'd1;
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        readdata    = readdata_q;
        err         = (state_q == StAck) && bad;
        waitrequest = 1'b1;
        if (reset) begin
            unique case (state_q)
                StIdle:  waitrequest = read || write;
                StBusy:  waitrequest = 1'b1;
                StAck:   waitrequest = 1'b0;
                default: waitrequest = 1'b1;
            endcase
        end
        dbg_word = dbg_region ? imem[dbg_index] : dmem[dbg_index];
    end

endmodule
